// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
//   mem_in_type  : request bus (valid, fence, instr, addr, wdata, wstrb)
//   mem_out_type : response bus (rdata, ready)
//   pend_t       : one buffered request held per requester port
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              mem_valid;
    logic              mem_fence;
    logic              mem_instr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
  } mem_out_type;

  typedef struct packed {
    logic              fence;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } pend_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: both requester ports and the shared downstream port.
//   imem_in / imem_out : instruction requester request / response
//   dmem_in / dmem_out : data requester request / response
//   mem_in  / mem_out  : shared downstream request / response
// slave  : arbiter side; master : requester + memory side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  mem_in_type  imem_in;
  mem_out_type imem_out;
  mem_in_type  dmem_in;
  mem_out_type dmem_out;
  mem_in_type  mem_in;
  mem_out_type mem_out;

  modport master (
    output imem_in, dmem_in, mem_out,
    input  imem_out, dmem_out, mem_in
  );

  modport slave (
    input  imem_in, dmem_in, mem_out,
    output imem_out, dmem_out, mem_in
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one shared memory bus.
// Each port has a one-entry pending buffer; one request is in flight at a time.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous, active-low reset
//   arb_if  : slave modport carrying imem_in/out, dmem_in/out, mem_in/out
// Parameters:
//   rr_enable  : 1 = round-robin on contention, 0 = data port always wins
//   fence_pass : 1 = forward buffered fence downstream, 0 = drive fence as 0
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit rr_enable  = 1'b1,
  parameter bit fence_pass = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave arb_if
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       ifull_q, ifull_d;
  logic       dfull_q, dfull_d;
  pend_t      ibuf_q, ibuf_d;
  pend_t      dbuf_q, dbuf_d;
  logic       last_d_q, last_d_d;   // 1 = data port won the last grant from IDLE
  mem_in_type mem_in_q, mem_in_d;

  logic i_resp_c, d_resp_c;
  logic i_cap_c, d_cap_c;
  logic i_elig_c, d_elig_c;
  logic pick_d_c;

  // Requester instr bits carry no meaning here; port identity comes from the grant.
  logic unused_instr_c;
  assign unused_instr_c = arb_if.imem_in.mem_instr ^ arb_if.dmem_in.mem_instr;

  function automatic pend_t to_pend(input mem_in_type r);
    pend_t p;
    p.fence = r.mem_fence;
    p.addr  = r.mem_addr;
    p.wdata = r.mem_wdata;
    p.wstrb = r.mem_wstrb;
    return p;
  endfunction

  function automatic mem_in_type issue_req(input pend_t b, input logic instr);
    mem_in_type r;
    r           = '0;
    r.mem_valid = 1'b1;
    r.mem_instr = instr;
    r.mem_fence = b.fence & fence_pass;
    r.mem_addr  = b.addr;
    r.mem_wdata = b.wdata;
    r.mem_wstrb = b.wstrb;
    return r;
  endfunction

  // A port is responded to only while it owns the bus; ready in IDLE is dropped.
  assign i_resp_c = (state_q == BUSY_I) && arb_if.mem_out.mem_ready;
  assign d_resp_c = (state_q == BUSY_D) && arb_if.mem_out.mem_ready;

  // Full buffer blocks re-capture, so a held valid never spawns a second request.
  assign i_cap_c  = arb_if.imem_in.mem_valid && !ifull_q && !i_resp_c;
  assign d_cap_c  = arb_if.dmem_in.mem_valid && !dfull_q && !d_resp_c;
  assign i_elig_c = ifull_q || i_cap_c;
  assign d_elig_c = dfull_q || d_cap_c;
  assign pick_d_c = rr_enable ? !last_d_q : 1'b1;

  // Pending buffers: capture when empty, release at the edge ending the response cycle.
  always_comb begin
    ifull_d = (ifull_q && !i_resp_c) || i_cap_c;
    dfull_d = (dfull_q && !d_resp_c) || d_cap_c;
    ibuf_d  = ibuf_q;
    dbuf_d  = dbuf_q;
    if (i_resp_c) ibuf_d = '0;
    if (d_resp_c) dbuf_d = '0;
    if (i_cap_c)  ibuf_d = to_pend(arb_if.imem_in);
    if (d_cap_c)  dbuf_d = to_pend(arb_if.dmem_in);
  end

  // Grant FSM; completion hands straight over to a waiting other port.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    unique case (state_q)
      IDLE: begin
        if (i_elig_c && d_elig_c) begin
          state_d  = pick_d_c ? BUSY_D : BUSY_I;
          last_d_d = pick_d_c;
        end else if (i_elig_c) begin
          state_d  = BUSY_I;
          last_d_d = 1'b0;
        end else if (d_elig_c) begin
          state_d  = BUSY_D;
          last_d_d = 1'b1;
        end
      end
      BUSY_I: begin
        if (arb_if.mem_out.mem_ready) state_d = d_elig_c ? BUSY_D : IDLE;
      end
      BUSY_D: begin
        if (arb_if.mem_out.mem_ready) state_d = i_elig_c ? BUSY_I : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream request is registered from the next state; all zero when idle.
  always_comb begin
    mem_in_d = '0;
    unique case (state_d)
      BUSY_I:  mem_in_d = issue_req(ibuf_d, 1'b1);
      BUSY_D:  mem_in_d = issue_req(dbuf_d, 1'b0);
      default: mem_in_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      ifull_q  <= 1'b0;
      dfull_q  <= 1'b0;
      ibuf_q   <= '0;
      dbuf_q   <= '0;
      last_d_q <= 1'b1;
      mem_in_q <= '0;
    end else begin
      state_q  <= state_d;
      ifull_q  <= ifull_d;
      dfull_q  <= dfull_d;
      ibuf_q   <= ibuf_d;
      dbuf_q   <= dbuf_d;
      last_d_q <= last_d_d;
      mem_in_q <= mem_in_d;
    end
  end

  assign arb_if.mem_in = mem_in_q;

  // Zero-latency response steering to the granted port only.
  always_comb begin
    arb_if.imem_out = '0;
    arb_if.dmem_out = '0;
    if (state_q == BUSY_I) arb_if.imem_out = arb_if.mem_out;
    if (state_q == BUSY_D) arb_if.dmem_out = arb_if.mem_out;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances run in lockstep,
// A = round-robin with fence forwarding, B = fixed data priority, fence blocked.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_arbiter_if ifa ();
  mem_arbiter_if ifb ();

  mem_arbiter u_dut_a (
    .clock  (clock),
    .reset  (reset),
    .arb_if (ifa)
  );

  mem_arbiter #(
    .rr_enable  (1'b0),
    .fence_pass (1'b0)
  ) u_dut_b (
    .clock  (clock),
    .reset  (reset),
    .arb_if (ifb)
  );

  // Memory model: ready after mem_lat extra cycles of a request, plus a forced stale ready.
  int unsigned mem_lat     = 1;
  logic        force_ready = 1'b0;
  int unsigned cnt_a = 0, cnt_b = 0;
  int unsigned ncomp_a = 0, ncomp_b = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return (addr == 32'h8000_1004) ? 32'hDEAD_BEEF : ~addr;
  endfunction

  assign ifa.mem_out.mem_ready = force_ready || (ifa.mem_in.mem_valid && cnt_a == mem_lat);
  assign ifa.mem_out.mem_rdata = mem_data(ifa.mem_in.mem_addr);
  assign ifb.mem_out.mem_ready = force_ready || (ifb.mem_in.mem_valid && cnt_b == mem_lat);
  assign ifb.mem_out.mem_rdata = mem_data(ifb.mem_in.mem_addr);

  always @(posedge clock) begin
    if (ifa.mem_in.mem_valid && !ifa.mem_out.mem_ready) cnt_a <= cnt_a + 1;
    else cnt_a <= 0;
    if (ifb.mem_in.mem_valid && !ifb.mem_out.mem_ready) cnt_b <= cnt_b + 1;
    else cnt_b <= 0;
    if (ifa.mem_in.mem_valid && ifa.mem_out.mem_ready) ncomp_a <= ncomp_a + 1;
    if (ifb.mem_in.mem_valid && ifb.mem_out.mem_ready) ncomp_b <= ncomp_b + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  // Same request to both instances; dport selects the data port.
  task automatic set_req(input bit dport, input logic v, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input logic fence);
    mem_in_type r;
    r           = '0;
    r.mem_valid = v;
    r.mem_fence = fence;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    if (dport) begin
      ifa.dmem_in = r;
      ifb.dmem_in = r;
    end else begin
      ifa.imem_in = r;
      ifb.imem_in = r;
    end
  endtask

  // Simultaneous pair with 1-cycle memory; B always serves data first.
  task automatic pair_round(input logic [31:0] ia, input logic [31:0] da, input bit a_dfirst);
    set_req(1'b0, 1'b1, ia, 32'h0, 4'h0, 1'b0);
    set_req(1'b1, 1'b1, da, 32'h0, 4'h0, 1'b0);
    cyc();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("pair_a_first_addr", ifa.mem_in.mem_addr, a_dfirst ? da : ia);
    check("pair_a_first_instr", 32'(ifa.mem_in.mem_instr), a_dfirst ? 32'd0 : 32'd1);
    check("pair_b_first_addr", ifb.mem_in.mem_addr, da);
    check("pair_b_first_instr", 32'(ifb.mem_in.mem_instr), 32'd0);
    cyc();
    check("pair_a_first_rdy", 32'(a_dfirst ? ifa.dmem_out.mem_ready : ifa.imem_out.mem_ready), 32'd1);
    check("pair_a_other_rdy", 32'(a_dfirst ? ifa.imem_out.mem_ready : ifa.dmem_out.mem_ready), 32'd0);
    check("pair_b_first_rdy", 32'(ifb.dmem_out.mem_ready), 32'd1);
    cyc();
    check("pair_a_second_valid", 32'(ifa.mem_in.mem_valid), 32'd1);
    check("pair_a_second_addr", ifa.mem_in.mem_addr, a_dfirst ? ia : da);
    check("pair_b_second_addr", ifb.mem_in.mem_addr, ia);
    check("pair_b_second_instr", 32'(ifb.mem_in.mem_instr), 32'd1);
    cyc();
    check("pair_a_second_rdata", a_dfirst ? ifa.imem_out.mem_rdata : ifa.dmem_out.mem_rdata,
          a_dfirst ? ~ia : ~da);
    check("pair_b_second_rdy", 32'(ifb.imem_out.mem_ready), 32'd1);
    cyc();
    check("pair_a_idle", 32'(ifa.mem_in.mem_valid), 32'd0);
    check("pair_b_idle", 32'(ifb.mem_in.mem_valid), 32'd0);
  endtask

  int unsigned base_a, base_b;

  initial begin
    reset       = 1'b0;
    ifa.imem_in = '0;
    ifb.imem_in = '0;
    ifa.dmem_in = '0;
    ifb.dmem_in = '0;
    // Request presented during reset must be ignored.
    set_req(1'b1, 1'b1, 32'h600, 32'h0, 4'h0, 1'b0);
    cyc(2);
    check("rst_valid", 32'(ifa.mem_in.mem_valid), 32'd0);
    check("rst_addr", ifa.mem_in.mem_addr, 32'h0);
    check("rst_dready", 32'(ifa.dmem_out.mem_ready), 32'd0);
    check("rst_irdata", ifa.imem_out.mem_rdata, 32'h0);
    check("rst_b_valid", 32'(ifb.mem_in.mem_valid), 32'd0);
    reset = 1'b1;
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc();
    check("no_cap_in_rst_a", 32'(ifa.mem_in.mem_valid), 32'd0);
    check("no_cap_in_rst_b", 32'(ifb.mem_in.mem_valid), 32'd0);

    // Single data read, memory ready two cycles after issue.
    mem_lat = 2;
    set_req(1'b1, 1'b1, 32'h8000_1004, 32'h0, 4'h0, 1'b0);
    cyc();
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("rd_valid1", 32'(ifa.mem_in.mem_valid), 32'd1);
    check("rd_instr", 32'(ifa.mem_in.mem_instr), 32'd0);
    check("rd_addr", ifa.mem_in.mem_addr, 32'h8000_1004);
    check("rd_dready1", 32'(ifa.dmem_out.mem_ready), 32'd0);
    cyc();
    check("rd_valid2", 32'(ifa.mem_in.mem_valid), 32'd1);
    cyc();
    check("rd_valid3", 32'(ifa.mem_in.mem_valid), 32'd1);
    check("rd_dready", 32'(ifa.dmem_out.mem_ready), 32'd1);
    check("rd_rdata", ifa.dmem_out.mem_rdata, 32'hDEAD_BEEF);
    check("rd_iready", 32'(ifa.imem_out.mem_ready), 32'd0);
    check("rd_irdata", ifa.imem_out.mem_rdata, 32'h0);
    check("rd_b_rdata", ifb.dmem_out.mem_rdata, 32'hDEAD_BEEF);
    cyc();
    check("rd_valid4", 32'(ifa.mem_in.mem_valid), 32'd0);
    check("rd_idle_addr", ifa.mem_in.mem_addr, 32'h0);
    check("rd_dready_after", 32'(ifa.dmem_out.mem_ready), 32'd0);

    // Three simultaneous pairs: A alternates I, D, I; B always data first.
    mem_lat = 1;
    pair_round(32'h100, 32'h200, 1'b0);
    pair_round(32'h104, 32'h204, 1'b1);
    pair_round(32'h108, 32'h208, 1'b0);
    check("pairs_done_a", ncomp_a, 32'd7);
    check("pairs_done_b", ncomp_b, 32'd7);

    // Data write with fence.
    set_req(1'b1, 1'b1, 32'h300, 32'h0000_ABCD, 4'h3, 1'b1);
    cyc();
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("wr_a_wstrb", 32'(ifa.mem_in.mem_wstrb), 32'h3);
    check("wr_a_wdata", ifa.mem_in.mem_wdata, 32'h0000_ABCD);
    check("wr_a_fence", 32'(ifa.mem_in.mem_fence), 32'd1);
    check("wr_b_fence", 32'(ifb.mem_in.mem_fence), 32'd0);
    check("wr_b_wstrb", 32'(ifb.mem_in.mem_wstrb), 32'h3);
    cyc(2);
    check("wr_idle_wstrb", 32'(ifa.mem_in.mem_wstrb), 32'h0);
    check("wr_idle_fence", 32'(ifa.mem_in.mem_fence), 32'd0);

    // Reset while BUSY_D, then a stale ready two cycles later.
    mem_lat = 2;
    set_req(1'b1, 1'b1, 32'h400, 32'h0, 4'h0, 1'b0);
    cyc();
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("mid_busy", 32'(ifa.mem_in.mem_valid), 32'd1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check("mid_rst_valid_a", 32'(ifa.mem_in.mem_valid), 32'd0);
    check("mid_rst_valid_b", 32'(ifb.mem_in.mem_valid), 32'd0);
    check("mid_rst_dready", 32'(ifa.dmem_out.mem_ready), 32'd0);
    cyc();
    force_ready = 1'b1;
    #1;
    check("stale_dready", 32'(ifa.dmem_out.mem_ready), 32'd0);
    check("stale_drdata", ifa.dmem_out.mem_rdata, 32'h0);
    check("stale_iready", 32'(ifa.imem_out.mem_ready), 32'd0);
    check("stale_valid", 32'(ifa.mem_in.mem_valid), 32'd0);
    cyc();
    force_ready = 1'b0;
    check("stale_after_valid", 32'(ifa.mem_in.mem_valid), 32'd0);
    set_req(1'b1, 1'b1, 32'h404, 32'h0, 4'h0, 1'b0);
    cyc();
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("post_rst_valid", 32'(ifa.mem_in.mem_valid), 32'd1);
    check("post_rst_addr", ifa.mem_in.mem_addr, 32'h404);
    cyc(2);
    check("post_rst_dready", 32'(ifa.dmem_out.mem_ready), 32'd1);
    check("post_rst_rdata", ifa.dmem_out.mem_rdata, 32'hFFFF_FBFB);
    cyc();
    check("post_rst_idle", 32'(ifa.mem_in.mem_valid), 32'd0);

    // Instruction valid held four cycles until its ready: one downstream request only.
    base_a = ncomp_a;
    base_b = ncomp_b;
    set_req(1'b0, 1'b1, 32'h500, 32'h0, 4'h0, 1'b0);
    cyc();
    check("hold_valid", 32'(ifa.mem_in.mem_valid), 32'd1);
    check("hold_instr", 32'(ifa.mem_in.mem_instr), 32'd1);
    cyc(2);
    check("hold_iready", 32'(ifa.imem_out.mem_ready), 32'd1);
    cyc();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("hold_no_reissue_a", 32'(ifa.mem_in.mem_valid), 32'd0);
    check("hold_no_reissue_b", 32'(ifb.mem_in.mem_valid), 32'd0);
    cyc();
    check("hold_still_idle", 32'(ifa.mem_in.mem_valid), 32'd0);
    check("hold_count_a", ncomp_a - base_a, 32'd1);
    check("hold_count_b", ncomp_b - base_b, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter rr_enable, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to the data port.
REQ-002 The block SHALL have parameter fence_pass, default 1, meaning 1 = forward mem_fence downstream and 0 = drive mem_fence as 0.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 clock  input  1  clock; all state changes on its rising edge.
REQ-005 imem_in  input  mem_in_type  instruction requester port (mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb).
REQ-006 imem_out  output  mem_out_type  instruction response (mem_rdata, mem_ready).
REQ-007 dmem_in  input  mem_in_type  data requester port, for example dtim backing traffic.
REQ-008 dmem_out  output  mem_out_type  data response.
REQ-009 mem_in  output  mem_in_type  shared downstream memory request.
REQ-010 mem_out  input  mem_out_type  shared downstream memory response.

Function
REQ-011 Each port SHALL have a one-entry pending buffer holding addr, wdata, wstrb and fence.
- Capture condition: mem_valid=1, buffer empty, and that port is not receiving mem_ready in that cycle.
- mem_valid held while a request is pending or in flight SHALL NOT create a second request.
REQ-012 Requesters SHALL deassert mem_valid no later than the cycle in which their mem_ready=1 is returned.
REQ-013 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D; no other states exist.
REQ-014 IDLE transitions:
- If any port's request is captured or pending at the clock edge, move to BUSY_I or BUSY_D per REQ-016.
- Otherwise stay in IDLE.
REQ-015 BUSY_x with mem_out.mem_ready=1:
- Complete port x.
- Go to BUSY of the other port if it is pending or being captured this cycle; otherwise go to IDLE.
- This allows back-to-back issue with no idle cycle.
REQ-016 When both ports are eligible in the same cycle:
- rr_enable=1: grant the port not granted last; the last-grant register resets to "data", so instruction wins first.
- rr_enable=0: grant the data port.
REQ-017 Downstream mem_in.mem_valid SHALL be registered and equal 1 exactly while in BUSY_I or BUSY_D, including the ready cycle.
- It drops the cycle after ready unless the next grant begins.
- addr, wdata, wstrb and fence stay stable for the whole BUSY period.
REQ-018 mem_in.mem_instr SHALL be 1 in BUSY_I and 0 otherwise.
- mem_in.mem_fence = buffered fence AND fence_pass.
- mem_in.mem_addr[1:0] is forwarded unchanged.
REQ-019 Response path:
- In BUSY_x, x_out.mem_ready = mem_out.mem_ready and x_out.mem_rdata = mem_out.mem_rdata, combinationally with 0-cycle latency.
- The non-granted port reads ready=0 and rdata=0.
REQ-020 Latency: a request captured at cycle N into an idle arbiter SHALL show mem_in.mem_valid=1 in cycle N+1; the earliest response is in cycle N+1.
REQ-021 mem_out.mem_ready received in IDLE SHALL be ignored and not forwarded; this covers stale responses.
REQ-022 A port's pending buffer SHALL clear at the clock edge that ends the cycle in which its response is returned.
REQ-023 mem_in.mem_valid=0 with mem_in.mem_wstrb=0 SHALL be read as a no-op by downstream.
- When idle, all mem_in data fields SHALL be 0.

Reset
REQ-024 With reset=0 at a rising edge, the block SHALL set:
- state = IDLE;
- both pending buffers empty;
- last-grant = data;
- all mem_in fields = 0;
- imem_out and dmem_out ready = 0 and rdata = 0.
REQ-025 Reset mid-transaction SHALL abandon the in-flight request with no response to either requester; the following stale mem_out.mem_ready is handled by REQ-021.
REQ-026 Requests presented while reset=0 SHALL NOT be captured.

Verification
REQ-027 Single read:
- Stimulus: dmem_in valid, addr=0x80001004, wstrb=0; memory returns ready with rdata=0xDEADBEEF two cycles after issue.
- Required: mem_in.mem_valid high for 3 cycles with instr=0; dmem_out.ready=1 with rdata=0xDEADBEEF in the third cycle; imem_out stays 0.
REQ-028 Simultaneous requests after reset (rr_enable=1):
- Stimulus: imem addr=0x100 and dmem addr=0x200 in the same cycle; memory ready after 1 cycle.
- Required: 0x100 is issued first with instr=1; 0x200 is issued in the cycle immediately after the ready cycle; then a repeat simultaneous pair is granted data first.
REQ-029 Fixed priority (rr_enable=0):
- Stimulus: three consecutive simultaneous pairs.
- Required: each pair serves data before instruction; no request is lost.
REQ-030 Write and fence:
- Stimulus: dmem write, wstrb=0x3, wdata=0x0000ABCD, fence=1.
- Required with fence_pass=1: mem_in shows wstrb=0x3 and fence=1.
- Required with fence_pass=0: fence=0.
REQ-031 Reset mid-transaction:
- Stimulus: reset=0 one cycle while in BUSY_D; memory asserts ready 2 cycles later.
- Required: mem_in.mem_valid=0 from the reset edge onward; dmem_out.ready never asserts; the next request is issued normally.
REQ-032 Held valid:
- Stimulus: imem_in valid held high for 4 cycles until ready; memory ready in cycle 3 of BUSY.
- Required: exactly one downstream request is issued.
